dbm_lane_mux: RTL and testbench

Parametrised debug-bus lane multiplexer. It is the successor to the fixed 8-segment debug mux select CSR. Each of NUM_SEGS output segments selects one LANE_WIDTH lane from NUM_LANES hardware input lanes. Selects are held in a shadow/active CSR pair with a glitch-free commit. A ROTATE mode sweeps all lanes automatically with a programmable dwell, and a FREEZE mode holds a snapshot. The block sits between block-level debug signal taps and the debug-bus/trace fabric, with a configurable registered output pipeline.

---
 rtl/dbm_lane_mux.sv | 169 ++++++++++++++++
 tb/tb_dbm_lane_mux.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbm_lane_mux.sv
// Debug-bus lane multiplexer: each of NUM_SEGS output segments picks one of NUM_LANES lanes.
// Shadow/active select CSRs with frame-aligned commit, ROTATE sweep, FREEZE snapshot, output pipeline.
module dbm_lane_mux #(
  parameter int NUM_LANES   = 64,
  parameter int LANE_WIDTH  = 8,
  parameter int NUM_SEGS    = 8,
  parameter int SEL_W       = $clog2(NUM_LANES),
  parameter int PIPE_STAGES = 2,
  parameter int DWELL_W     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] hw_lanes_i,
  input  logic                            cfg_wr_en,
  input  logic [NUM_SEGS*SEL_W-1:0]       cfg_sel_i,
  input  logic [1:0]                      cfg_mode_i,
  input  logic [5:0]                      cfg_id_i,
  input  logic [DWELL_W-1:0]              cfg_dwell_i,
  input  logic                            commit_i,
  output logic                            cfg_busy_o,
  output logic [NUM_SEGS*LANE_WIDTH-1:0]  dbm_data_o,
  output logic                            dbm_valid_o,
  output logic [5:0]                      dbm_id_o,
  output logic [SEL_W-1:0]                dbm_offset_o
);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_ROTATE = 2'd2;
  localparam logic [1:0] MODE_FREEZE = 2'd3;

  localparam int               DATA_W   = NUM_SEGS * LANE_WIDTH;
  localparam logic [SEL_W-1:0] SEG_STEP = SEL_W'(NUM_SEGS);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              valid;
    logic [5:0]        id;
    logic [SEL_W-1:0]  offset;
  } stage_t;

  logic [NUM_SEGS*SEL_W-1:0] sh_sel, act_sel, cur_sel;
  logic [1:0]                sh_mode, act_mode, cur_mode;
  logic [5:0]                sh_id, act_id, cur_id;
  logic [DWELL_W-1:0]        sh_dwell, act_dwell, cur_dwell;

  logic                      pending;
  logic                      commit_now;
  logic                      rot_enter;
  logic [SEL_W-1:0]          offset;
  logic [SEL_W-1:0]          app_offset;
  logic [DWELL_W-1:0]        dwell_cnt;

  logic [LANE_WIDTH-1:0]     lanes   [NUM_LANES];
  logic [SEL_W-1:0]          eff_sel [NUM_SEGS];
  stage_t                    stage_d;
  stage_t                    stage_q [PIPE_STAGES];

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lanes[k] = hw_lanes_i[k*LANE_WIDTH +: LANE_WIDTH];
  end

  // In ROTATE a commit lands only on a frame boundary so a frame is never torn.
  assign commit_now = pending && ((act_mode != MODE_ROTATE) || (dwell_cnt == '0));

  // The copy edge already runs under the committed set, so the new config is captured at once.
  assign cur_sel   = commit_now ? sh_sel   : act_sel;
  assign cur_mode  = commit_now ? sh_mode  : act_mode;
  assign cur_id    = commit_now ? sh_id    : act_id;
  assign cur_dwell = commit_now ? sh_dwell : act_dwell;

  assign rot_enter  = commit_now && (cur_mode == MODE_ROTATE) &&
                      ((act_mode == MODE_OFF) || (act_mode == MODE_STATIC));
  assign app_offset = (cur_mode == MODE_ROTATE) ? offset : '0;
  assign cfg_busy_o = pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_sel    <= '0;
      sh_mode   <= MODE_OFF;
      sh_id     <= '0;
      sh_dwell  <= '0;
      act_sel   <= '0;
      act_mode  <= MODE_OFF;
      act_id    <= '0;
      act_dwell <= '0;
      pending   <= 1'b0;
    end else begin
      if (cfg_wr_en) begin
        sh_sel   <= cfg_sel_i;
        sh_mode  <= cfg_mode_i;
        sh_id    <= cfg_id_i;
        sh_dwell <= cfg_dwell_i;
      end
      if (commit_now) begin
        act_sel   <= sh_sel;
        act_mode  <= sh_mode;
        act_id    <= sh_id;
        act_dwell <= sh_dwell;
      end
      // A repeated commit_i only keeps the flag set; whatever the shadow holds at copy time wins.
      if (commit_i)        pending <= 1'b1;
      else if (commit_now) pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      offset    <= '0;
      dwell_cnt <= '0;
    end else begin
      case (cur_mode)
        MODE_ROTATE: begin
          if (rot_enter) begin
            offset    <= '0;
            dwell_cnt <= cur_dwell;
          end else if (dwell_cnt == '0) begin
            offset    <= offset + SEG_STEP;
            dwell_cnt <= cur_dwell;
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        MODE_FREEZE: begin
          // Offset and counter hold so a later return to ROTATE resumes the sweep.
        end
        default: begin
          offset    <= '0;
          dwell_cnt <= cur_dwell;
        end
      endcase
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SEGS; s++) begin
      eff_sel[s] = cur_sel[s*SEL_W +: SEL_W] + app_offset;
    end
  end

  always_comb begin
    // NOTE: every field gets a default before the mode decode, so no latch can be inferred.
    stage_d        = '0;
    stage_d.id     = cur_id;
    stage_d.offset = app_offset;
    if ((cur_mode == MODE_STATIC) || (cur_mode == MODE_ROTATE)) begin
      stage_d.valid = 1'b1;
      for (int s = 0; s < NUM_SEGS; s++) begin
        stage_d.data[s*LANE_WIDTH +: LANE_WIDTH] = lanes[eff_sel[s]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the pipeline is reset as well, so a frozen snapshot cannot survive a reset.
      for (int i = 0; i < PIPE_STAGES; i++) stage_q[i] <= '0;
    end else begin
      if (cur_mode != MODE_FREEZE) stage_q[0] <= stage_d;
      for (int i = 1; i < PIPE_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dbm_data_o   = stage_q[PIPE_STAGES-1].data;
  assign dbm_valid_o  = stage_q[PIPE_STAGES-1].valid;
  assign dbm_id_o     = stage_q[PIPE_STAGES-1].id;
  assign dbm_offset_o = stage_q[PIPE_STAGES-1].offset;

endmodule

// File: tb/tb_dbm_lane_mux.sv
// Directed self-checking bench for dbm_lane_mux at default parameters (64 lanes, 8 segments, 2 stages).
module tb_dbm_lane_mux;

  localparam int NL = 64;
  localparam int LW = 8;
  localparam int NS = 8;
  localparam int SW = 6;
  localparam int PS = 2;
  localparam int DW = 8;

  localparam logic [1:0] M_OFF    = 2'd0;
  localparam logic [1:0] M_STATIC = 2'd1;
  localparam logic [1:0] M_ROTATE = 2'd2;
  localparam logic [1:0] M_FREEZE = 2'd3;

  logic             clk = 1'b0;
  logic             reset;
  logic [NL*LW-1:0] hw_lanes_i;
  logic             cfg_wr_en;
  logic [NS*SW-1:0] cfg_sel_i;
  logic [1:0]       cfg_mode_i;
  logic [5:0]       cfg_id_i;
  logic [DW-1:0]    cfg_dwell_i;
  logic             commit_i;
  logic             cfg_busy_o;
  logic [NS*LW-1:0] dbm_data_o;
  logic             dbm_valid_o;
  logic [5:0]       dbm_id_o;
  logic [SW-1:0]    dbm_offset_o;

  logic [NS*SW-1:0] sel_ramp;
  logic [NS*SW-1:0] sel_all63;
  int               n_checks = 0;
  int               n_errors = 0;

  dbm_lane_mux #(
    .NUM_LANES  (NL),
    .LANE_WIDTH (LW),
    .NUM_SEGS   (NS),
    .SEL_W      (SW),
    .PIPE_STAGES(PS),
    .DWELL_W    (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hw_lanes_i  (hw_lanes_i),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_sel_i   (cfg_sel_i),
    .cfg_mode_i  (cfg_mode_i),
    .cfg_id_i    (cfg_id_i),
    .cfg_dwell_i (cfg_dwell_i),
    .commit_i    (commit_i),
    .cfg_busy_o  (cfg_busy_o),
    .dbm_data_o  (dbm_data_o),
    .dbm_valid_o (dbm_valid_o),
    .dbm_id_o    (dbm_id_o),
    .dbm_offset_o(dbm_offset_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [7:0] base);
    for (int k = 0; k < NL; k++) hw_lanes_i[k*LW +: LW] = base + 8'(k);
  endtask

  task automatic write_cfg(input logic [1:0] mode, input logic [5:0] id, input logic [DW-1:0] dwell,
                           input logic [NS*SW-1:0] sel, input logic with_commit);
    cfg_wr_en   = 1'b1;
    cfg_mode_i  = mode;
    cfg_id_i    = id;
    cfg_dwell_i = dwell;
    cfg_sel_i   = sel;
    commit_i    = with_commit;
    tick();
    cfg_wr_en   = 1'b0;
    commit_i    = 1'b0;
  endtask

  task automatic commit();
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
  endtask

  task automatic wait_busy_low(input string tag, output int n);
    n = 0;
    while (cfg_busy_o && n < 40) begin
      tick();
      n++;
    end
    check(tag, 64'(cfg_busy_o), 64'd0);
  endtask

  task automatic wait_offset_change(input string tag);
    logic [SW-1:0] prev;
    bit            seen;
    prev = dbm_offset_o;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (dbm_offset_o != prev) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    int            nb;
    bit            seen;
    bit            seen_2a;
    logic [SW-1:0] e;

    for (int s = 0; s < NS; s++) sel_ramp[s*SW +: SW] = SW'(s);
    sel_all63   = '1;
    reset       = 1'b1;
    cfg_wr_en   = 1'b0;
    cfg_sel_i   = '0;
    cfg_mode_i  = M_OFF;
    cfg_id_i    = '0;
    cfg_dwell_i = '0;
    commit_i    = 1'b0;
    set_lanes(8'h00);
    tick();
    tick();
    check("rst_data", dbm_data_o, 64'd0);
    check("rst_valid", 64'(dbm_valid_o), 64'd0);
    check("rst_id", 64'(dbm_id_o), 64'd0);
    check("rst_offset", 64'(dbm_offset_o), 64'd0);
    check("rst_busy", 64'(cfg_busy_o), 64'd0);
    reset = 1'b0;

    // STATIC with commit latency
    write_cfg(M_STATIC, 6'h15, 8'd0, sel_ramp, 1'b0);
    commit();
    check("static_busy_on", 64'(cfg_busy_o), 64'd1);
    tick();
    check("static_busy_off", 64'(cfg_busy_o), 64'd0);
    check("static_not_yet", 64'(dbm_valid_o), 64'd0);
    tick();
    check("static_data", dbm_data_o, 64'h0706050403020100);
    check("static_valid", 64'(dbm_valid_o), 64'd1);
    check("static_id", 64'(dbm_id_o), 64'h15);
    check("static_offset", 64'(dbm_offset_o), 64'd0);

    // lane-to-output latency
    set_lanes(8'h40);
    tick();
    check("lane_lat_old", dbm_data_o, 64'h0706050403020100);
    tick();
    check("lane_lat_new", dbm_data_o, 64'h4746454443424140);

    // FREEZE holds the snapshot while lanes toggle
    write_cfg(M_FREEZE, 6'h15, 8'd0, sel_ramp, 1'b0);
    commit();
    set_lanes(8'h80);
    for (int i = 0; i < 4; i++) tick();
    check("freeze_data", dbm_data_o, 64'h4746454443424140);
    check("freeze_valid", 64'(dbm_valid_o), 64'd1);
    set_lanes(8'hC0);
    tick();
    tick();
    check("freeze_data2", dbm_data_o, 64'h4746454443424140);
    write_cfg(M_STATIC, 6'h15, 8'd0, sel_ramp, 1'b0);
    commit();
    tick();
    tick();
    check("unfreeze_data", dbm_data_o, 64'hC7C6C5C4C3C2C1C0);
    set_lanes(8'h00);
    tick();
    tick();
    check("unfreeze_track", dbm_data_o, 64'h0706050403020100);

    // ROTATE sweep with dwell 3 (same-cycle write and commit)
    write_cfg(M_ROTATE, 6'h15, 8'd3, sel_ramp, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (dbm_offset_o == 6'd8) seen = 1'b1;
    end
    check("rot_first_step", 64'(seen), 64'd1);
    for (int i = 0; i < 32; i++) begin
      e = SW'((8 + 8 * (i / 4)) % 64);
      check("rot_offset", 64'(dbm_offset_o), 64'(e));
      check("rot_seg0", 64'(dbm_data_o[7:0]), 64'(e));
      check("rot_seg7", 64'(dbm_data_o[63:56]), 64'(e) + 64'd7);
      check("rot_valid", 64'(dbm_valid_o), 64'd1);
      tick();
    end

    // Deferred commit: ROTATE dwell 9, commit on the second cycle of a frame
    write_cfg(M_ROTATE, 6'h15, 8'd9, sel_ramp, 1'b1);
    wait_busy_low("defer_setup", nb);
    write_cfg(M_STATIC, 6'h15, 8'd0, sel_all63, 1'b0);
    wait_offset_change("defer_frame_sync");
    for (int i = 0; i < 9; i++) tick();
    commit();
    check("defer_busy_on", 64'(cfg_busy_o), 64'd1);
    wait_busy_low("defer_busy_end", nb);
    check("defer_busy_cycles", 64'(nb), 64'd8);
    tick();
    check("defer_data", dbm_data_o, 64'h3F3F3F3F3F3F3F3F);
    check("defer_offset", 64'(dbm_offset_o), 64'd0);
    check("defer_valid", 64'(dbm_valid_o), 64'd1);

    // Same-cycle write+commit followed by a second commit while pending
    write_cfg(M_ROTATE, 6'h15, 8'd9, sel_ramp, 1'b1);
    wait_busy_low("dbl_setup", nb);
    wait_offset_change("dbl_frame_sync");
    write_cfg(M_ROTATE, 6'h2A, 8'd9, sel_ramp, 1'b1);
    write_cfg(M_ROTATE, 6'h11, 8'd9, sel_ramp, 1'b1);
    check("dbl_busy_on", 64'(cfg_busy_o), 64'd1);
    seen_2a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dbm_id_o == 6'h2A) seen_2a = 1'b1;
    end
    check("dbl_no_2a", 64'(seen_2a), 64'd0);
    check("dbl_id", 64'(dbm_id_o), 64'h11);
    check("dbl_busy_off", 64'(cfg_busy_o), 64'd0);

    // OFF drains to zero
    write_cfg(M_OFF, 6'h15, 8'd0, sel_ramp, 1'b1);
    wait_busy_low("off_commit", nb);
    check("off_drain_lat", 64'(dbm_valid_o), 64'd1);
    tick();
    check("off_data", dbm_data_o, 64'd0);
    check("off_valid", 64'(dbm_valid_o), 64'd0);
    check("off_offset", 64'(dbm_offset_o), 64'd0);

    // Reset while a commit is pending in ROTATE
    write_cfg(M_ROTATE, 6'h15, 8'd9, sel_ramp, 1'b1);
    wait_busy_low("mid_rst_setup", nb);
    write_cfg(M_STATIC, 6'h15, 8'd0, sel_ramp, 1'b1);
    check("mid_rst_pending", 64'(cfg_busy_o), 64'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_data", dbm_data_o, 64'd0);
    check("mid_rst_valid", 64'(dbm_valid_o), 64'd0);
    check("mid_rst_id", 64'(dbm_id_o), 64'd0);
    check("mid_rst_offset", 64'(dbm_offset_o), 64'd0);
    check("mid_rst_busy", 64'(cfg_busy_o), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_busy", 64'(cfg_busy_o), 64'd0);
    check("post_rst_valid", 64'(dbm_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
